t03_player_action_fsm: RTL and testbench
========================================

// Module: t03_player_action_fsm
// PURPOSE
// - Per-player action sequencer for NUM_PLAYERS fighters: attack, block, cooldown and hit-stun.
// - Advances only on the frame tick (finished); emits registered state, resting and hit/block windows.
// - Sits between the debounced button inputs and the collision/health logic.
// - Adds timed hit windows, cooldown with re-arm, stun on hit and configurable press priority.
// PARAMETERS
// - NUM_PLAYERS  2   independent player channels
// - CNT_W        8   frame-counter width; every *_LEN must be < 2**CNT_W
// - ATK_LEN      24  attack duration in ticks (>=1)
// - ATK_HIT_S    8   first tick (counter value) of the attack hit window
// - ATK_HIT_E    15  last tick of the hit window (ATK_HIT_S<=ATK_HIT_E<ATK_LEN)
// - BLK_MAX      40  maximum block hold in ticks
// - CD_LEN       12  cooldown duration in ticks
// - STUN_LEN     30  hit-stun duration in ticks
// - B_PRIORITY   0   0: attack wins when A and B are pressed together; 1: block wins
// PORTS
// - clk            in   1        system clock
// - rst            in   1        reset, asynchronous, active-low
// - finished       in   1        frame tick; the FSM advances only on cycles where it is 1
// - btn_a_n        in   N        attack buttons, active-low, one bit per player
// - btn_b_n        in   N        block buttons, active-low
// - hit_in         in   N        player p was struck this tick (from collision)
// - player_state   out  3*N      per-player state code, player p at [3p+2:3p]
// - resting        out  N        1 = vulnerable/idle pose (IDLE, COOLDOWN, STUN)
// - attack_active  out  N        1 = hit window open
// - block_active   out  N        1 = blocking
// - hit_taken      out  N        one-tick pulse: hit accepted, STUN entered
// BEHAVIOUR
// - Reset (async, rst=0): state=IDLE, counter=0, armed=1, resting=1, all other outputs 0.
// - All outputs are registered and update on the clk edge where finished=1; they hold otherwise.
// - State codes: IDLE=0, ATTACK=1, BLOCK=2, COOLDOWN=3, STUN=4. Codes 5-7 go to IDLE with resting=1.
// - Counter: clears on every state entry, increments once per tick and saturates at all-ones.
// - IDLE: resting=1. If armed and A pressed, go to ATTACK; if armed and B pressed, go to BLOCK.
// - IDLE, both pressed: B_PRIORITY selects. Not armed: ignore buttons; armed sets to 1 once both are released.
// - ATTACK: resting=0. attack_active=1 when ATK_HIT_S<=counter<=ATK_HIT_E.
// - ATTACK: cannot be cancelled by buttons; at counter==ATK_LEN-1 go to COOLDOWN.
// - BLOCK: block_active=1, resting=0. Go to COOLDOWN when B is released or counter==BLK_MAX-1.
// - COOLDOWN: resting=1. At counter==CD_LEN-1 go to IDLE with armed=0. A held button never auto-repeats.
// - hit_in on a tick while not BLOCK: go to STUN, pulse hit_taken, clear attack_active.
// - hit_in takes priority over every other transition that tick.
// - hit_in while in BLOCK: ignored (no pulse). hit_in while in STUN: ignored, and the counter does not restart.
// - STUN: resting=1. At counter==STUN_LEN-1 go to IDLE with armed=0.
// - Channels are fully independent; no cross-player priority.
// - Reset mid-action returns immediately to IDLE with resting=1.
// STRUCTURE
// - Package t03_player_pkg: state enum/localparams IDLE..STUN and the state-code width (3).
// - Sub-module t03_player_action_ch: one channel (FSM, counter, armed flag, registered outputs).
// - Top level instantiates NUM_PLAYERS copies in a generate loop and packs the output buses.
// TESTING (bench params: ATK_LEN=8, HIT 3..5, BLK_MAX=6, CD_LEN=4, STUN_LEN=5, finished every cycle)
// - Reset mid-ATTACK: drop rst -> state 0, resting=1, all windows 0 in the same cycle, before the next clk edge.
// - Attack: hold A on p0 -> state 1 for 8 ticks, attack_active high on counter 3,4,5 only;
//   then state 3 for 4 ticks, then IDLE; no re-entry until A is released.
// - Block: hold B -> block_active for 6 ticks then COOLDOWN. Release B at tick 2 -> COOLDOWN on the next tick.
// - Simultaneous A+B in IDLE: B_PRIORITY=0 -> ATTACK; B_PRIORITY=1 -> BLOCK.
// - Hit: hit_in during ATTACK tick 4 -> STUN, one hit_taken pulse, attack_active=0.
//   hit_in during BLOCK -> no state change. Repeat hit_in during STUN -> STUN still exits after 5 ticks.
// - finished gating: finished=0 for 10 cycles mid-ATTACK -> state, counter and outputs frozen.
//   Two players driven concurrently with different inputs -> no interaction.

Source files
------------

// File: rtl/t03_player_pkg.sv
// Shared state encoding for the per-player action sequencer.
// Codes 5-7 are unused and recover to IDLE.
package t03_player_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE     = 3'd0,
    ST_ATTACK   = 3'd1,
    ST_BLOCK    = 3'd2,
    ST_COOLDOWN = 3'd3,
    ST_STUN     = 3'd4
  } state_t;

endpackage

// File: rtl/t03_player_action_fsm_if.sv
// Button/collision inputs and per-player status outputs of the action sequencer.
// slave = sequencer side, master = stimulus / game-logic side.
interface t03_player_action_fsm_if #(
  parameter int NUM_PLAYERS = 2
);

  logic                                         finished;
  logic [NUM_PLAYERS-1:0]                       btn_a_n;
  logic [NUM_PLAYERS-1:0]                       btn_b_n;
  logic [NUM_PLAYERS-1:0]                       hit_in;
  logic [t03_player_pkg::STATE_W*NUM_PLAYERS-1:0] player_state;
  logic [NUM_PLAYERS-1:0]                       resting;
  logic [NUM_PLAYERS-1:0]                       attack_active;
  logic [NUM_PLAYERS-1:0]                       block_active;
  logic [NUM_PLAYERS-1:0]                       hit_taken;

  modport slave (
    input  finished, btn_a_n, btn_b_n, hit_in,
    output player_state, resting, attack_active, block_active, hit_taken
  );

  modport master (
    output finished, btn_a_n, btn_b_n, hit_in,
    input  player_state, resting, attack_active, block_active, hit_taken
  );

endinterface

// File: rtl/t03_player_action_ch.sv
// One player channel: state register, frame counter, re-arm flag and registered outputs.
// Everything advances only on frame ticks (i_finished=1).
module t03_player_action_ch
  import t03_player_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int ATK_LEN    = 24,
  parameter int ATK_HIT_S  = 8,
  parameter int ATK_HIT_E  = 15,
  parameter int BLK_MAX    = 40,
  parameter int CD_LEN     = 12,
  parameter int STUN_LEN   = 30,
  parameter int B_PRIORITY = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_finished,
  input  logic               i_btn_a_n,
  input  logic               i_btn_b_n,
  input  logic               i_hit,
  output logic [STATE_W-1:0] o_state,
  output logic               o_resting,
  output logic               o_attack_active,
  output logic               o_block_active,
  output logic               o_hit_taken
);

  localparam logic [CNT_W-1:0] ATK_LAST  = CNT_W'(ATK_LEN - 1);
  localparam logic [CNT_W-1:0] BLK_LAST  = CNT_W'(BLK_MAX - 1);
  localparam logic [CNT_W-1:0] CD_LAST   = CNT_W'(CD_LEN - 1);
  localparam logic [CNT_W-1:0] STUN_LAST = CNT_W'(STUN_LEN - 1);
  localparam logic [CNT_W-1:0] HIT_S     = CNT_W'(ATK_HIT_S);
  localparam logic [CNT_W-1:0] HIT_E     = CNT_W'(ATK_HIT_E);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_armed;
  logic             w_armed_next;
  logic             r_resting;
  logic             r_attack_active;
  logic             r_block_active;
  logic             r_hit_taken;
  logic             w_hit_accept;
  logic             w_a;
  logic             w_b;

  assign w_a = ~i_btn_a_n;
  assign w_b = ~i_btn_b_n;

  always_comb begin
    w_state_next = r_state;
    w_armed_next = r_armed;
    w_hit_accept = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_armed) begin
          if (w_a && w_b) begin
            w_state_next = (B_PRIORITY != 0) ? ST_BLOCK : ST_ATTACK;
          end else if (w_a) begin
            w_state_next = ST_ATTACK;
          end else if (w_b) begin
            w_state_next = ST_BLOCK;
          end
        end else if (!w_a && !w_b) begin
          w_armed_next = 1'b1;
        end
      end
      ST_ATTACK: begin
        if (r_cnt == ATK_LAST) w_state_next = ST_COOLDOWN;
      end
      ST_BLOCK: begin
        if (!w_b || r_cnt == BLK_LAST) w_state_next = ST_COOLDOWN;
      end
      ST_COOLDOWN: begin
        if (r_cnt == CD_LAST) begin
          w_state_next = ST_IDLE;
          w_armed_next = 1'b0;
        end
      end
      ST_STUN: begin
        if (r_cnt == STUN_LAST) begin
          w_state_next = ST_IDLE;
          w_armed_next = 1'b0;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    // A hit pre-empts any other transition; blocking and an active stun absorb it.
    if (i_hit && r_state != ST_BLOCK && r_state != ST_STUN) begin
      w_state_next = ST_STUN;
      w_hit_accept = 1'b1;
    end

    if (w_state_next != r_state) begin
      w_cnt_next = '0;
    end else if (r_cnt == CNT_MAX) begin
      w_cnt_next = r_cnt;
    end else begin
      w_cnt_next = r_cnt + 1'b1;
    end
  end

  // Outputs are derived from the next state/counter so they line up with the registered state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= ST_IDLE;
      r_cnt           <= '0;
      r_armed         <= 1'b1;
      r_resting       <= 1'b1;
      r_attack_active <= 1'b0;
      r_block_active  <= 1'b0;
      r_hit_taken     <= 1'b0;
    end else if (i_finished) begin
      r_state         <= w_state_next;
      r_cnt           <= w_cnt_next;
      r_armed         <= w_armed_next;
      r_resting       <= (w_state_next != ST_ATTACK) && (w_state_next != ST_BLOCK);
      r_attack_active <= (w_state_next == ST_ATTACK) && (w_cnt_next >= HIT_S) &&
                         (w_cnt_next <= HIT_E);
      r_block_active  <= (w_state_next == ST_BLOCK);
      r_hit_taken     <= w_hit_accept;
    end
  end

  assign o_state         = r_state;
  assign o_resting       = r_resting;
  assign o_attack_active = r_attack_active;
  assign o_block_active  = r_block_active;
  assign o_hit_taken     = r_hit_taken;

endmodule

// File: rtl/t03_player_action_fsm.sv
// Top of the action sequencer: NUM_PLAYERS independent channels with packed status buses.
// Player p's state code sits at player_state[3p+2:3p].
module t03_player_action_fsm
  import t03_player_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int CNT_W       = 8,
  parameter int ATK_LEN     = 24,
  parameter int ATK_HIT_S   = 8,
  parameter int ATK_HIT_E   = 15,
  parameter int BLK_MAX     = 40,
  parameter int CD_LEN      = 12,
  parameter int STUN_LEN    = 30,
  parameter int B_PRIORITY  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  t03_player_action_fsm_if.slave bus
);

  logic [STATE_W*NUM_PLAYERS-1:0] w_state;
  logic [NUM_PLAYERS-1:0]         w_resting;
  logic [NUM_PLAYERS-1:0]         w_attack_active;
  logic [NUM_PLAYERS-1:0]         w_block_active;
  logic [NUM_PLAYERS-1:0]         w_hit_taken;

  generate
    for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_ch
      t03_player_action_ch #(
        .CNT_W      (CNT_W),
        .ATK_LEN    (ATK_LEN),
        .ATK_HIT_S  (ATK_HIT_S),
        .ATK_HIT_E  (ATK_HIT_E),
        .BLK_MAX    (BLK_MAX),
        .CD_LEN     (CD_LEN),
        .STUN_LEN   (STUN_LEN),
        .B_PRIORITY (B_PRIORITY)
      ) u_ch (
        .clk             (clk),
        .rst             (rst),
        .i_finished      (bus.finished),
        .i_btn_a_n       (bus.btn_a_n[gi]),
        .i_btn_b_n       (bus.btn_b_n[gi]),
        .i_hit           (bus.hit_in[gi]),
        .o_state         (w_state[STATE_W*gi +: STATE_W]),
        .o_resting       (w_resting[gi]),
        .o_attack_active (w_attack_active[gi]),
        .o_block_active  (w_block_active[gi]),
        .o_hit_taken     (w_hit_taken[gi])
      );
    end
  endgenerate

  assign bus.player_state  = w_state;
  assign bus.resting       = w_resting;
  assign bus.attack_active = w_attack_active;
  assign bus.block_active  = w_block_active;
  assign bus.hit_taken     = w_hit_taken;

endmodule

// File: tb/tb_t03_player_action_fsm.sv
// Directed bench: two sequencer instances (attack priority and block priority) on short timings.
// Inputs change 1 ns after the rising edge; outputs are checked at the same point.
module tb_t03_player_action_fsm;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  t03_player_action_fsm_if #(.NUM_PLAYERS(2)) bus0 ();
  t03_player_action_fsm_if #(.NUM_PLAYERS(2)) bus1 ();

  t03_player_action_fsm #(
    .NUM_PLAYERS(2), .CNT_W(8), .ATK_LEN(8), .ATK_HIT_S(3), .ATK_HIT_E(5),
    .BLK_MAX(6), .CD_LEN(4), .STUN_LEN(5), .B_PRIORITY(0)
  ) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  t03_player_action_fsm #(
    .NUM_PLAYERS(2), .CNT_W(8), .ATK_LEN(8), .ATK_HIT_S(3), .ATK_HIT_E(5),
    .BLK_MAX(6), .CD_LEN(4), .STUN_LEN(5), .B_PRIORITY(1)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  logic [2:0] s0p0, s0p1, s1p0;
  assign s0p0 = bus0.player_state[2:0];
  assign s0p1 = bus0.player_state[5:3];
  assign s1p0 = bus1.player_state[2:0];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    bus0.finished = 1'b1;  bus1.finished = 1'b1;
    bus0.btn_a_n  = 2'b11; bus1.btn_a_n  = 2'b11;
    bus0.btn_b_n  = 2'b11; bus1.btn_b_n  = 2'b11;
    bus0.hit_in   = 2'b00; bus1.hit_in   = 2'b00;

    // Reset state
    #2 rst = 1'b0;
    #1;
    check_val("rst_state0", bus0.player_state, 0);
    check_val("rst_state1", bus1.player_state, 0);
    check_val("rst_resting", bus0.resting, 2'b11);
    check_val("rst_atk", bus0.attack_active, 0);
    check_val("rst_blk", bus0.block_active, 0);
    check_val("rst_hit", bus0.hit_taken, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    $display("reset checked");

    // Attack on p0 held through cooldown
    bus0.btn_a_n[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      check_val($sformatf("atk_state k%0d", k), s0p0, 1);
      check_val($sformatf("atk_win k%0d", k), bus0.attack_active[0], (k >= 3 && k <= 5) ? 1 : 0);
      check_val($sformatf("atk_rest k%0d", k), bus0.resting[0], 0);
      check_val($sformatf("atk_p1 k%0d", k), s0p1, 0);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      check_val($sformatf("cd_state k%0d", k), s0p0, 3);
      check_val($sformatf("cd_rest k%0d", k), bus0.resting[0], 1);
    end
    tick();
    check_val("cd_exit", s0p0, 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_val($sformatf("no_repeat k%0d", k), s0p0, 0);
    end
    bus0.btn_a_n[0] = 1'b1;
    tick();
    check_val("rearm_idle", s0p0, 0);
    $display("attack sequence done");

    // Hit at attack tick 4, then repeated hits during stun
    bus0.btn_a_n[0] = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check_val("atk2_cnt4_state", s0p0, 1);
    check_val("atk2_cnt4_win", bus0.attack_active[0], 1);
    bus0.hit_in[0] = 1'b1;
    tick();
    check_val("hit_state", s0p0, 4);
    check_val("hit_pulse", bus0.hit_taken, 2'b01);
    check_val("hit_win", bus0.attack_active[0], 0);
    check_val("hit_rest", bus0.resting[0], 1);
    for (int k = 1; k <= 4; k++) begin
      bus0.hit_in[0] = (k <= 2);
      tick();
      check_val($sformatf("stun_state k%0d", k), s0p0, 4);
      check_val($sformatf("stun_pulse k%0d", k), bus0.hit_taken, 0);
    end
    bus0.hit_in[0] = 1'b0;
    tick();
    check_val("stun_exit", s0p0, 0);
    bus0.btn_a_n[0] = 1'b1;
    tick();
    $display("hit/stun sequence done");

    // Block held to maximum, with a hit absorbed mid-block
    bus0.btn_b_n[0] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      bus0.hit_in[0] = (k == 2);
      tick();
      check_val($sformatf("blk_state k%0d", k), s0p0, 2);
      check_val($sformatf("blk_act k%0d", k), bus0.block_active[0], 1);
      check_val($sformatf("blk_rest k%0d", k), bus0.resting[0], 0);
      check_val($sformatf("blk_pulse k%0d", k), bus0.hit_taken, 0);
    end
    bus0.hit_in[0] = 1'b0;
    tick();
    check_val("blk_max_state", s0p0, 3);
    check_val("blk_max_act", bus0.block_active[0], 0);
    for (int k = 1; k < 4; k++) tick();
    tick();
    check_val("blk_cd_exit", s0p0, 0);
    tick();
    check_val("blk_no_repeat", s0p0, 0);
    bus0.btn_b_n[0] = 1'b1;
    tick();
    $display("block max sequence done");

    // Block released at tick 2
    bus0.btn_b_n[0] = 1'b0;
    tick(); tick(); tick();
    check_val("blk_rel_cnt2", s0p0, 2);
    bus0.btn_b_n[0] = 1'b1;
    tick();
    check_val("blk_rel_state", s0p0, 3);
    check_val("blk_rel_act", bus0.block_active[0], 0);
    for (int k = 1; k < 4; k++) tick();
    tick();
    check_val("blk_rel_exit", s0p0, 0);
    tick();
    $display("block release sequence done");

    // Simultaneous A+B on both priority variants
    bus0.btn_a_n[0] = 1'b0; bus0.btn_b_n[0] = 1'b0;
    bus1.btn_a_n[0] = 1'b0; bus1.btn_b_n[0] = 1'b0;
    tick();
    check_val("prio0_state", s0p0, 1);
    check_val("prio1_state", s1p0, 2);
    bus0.btn_a_n = 2'b11; bus0.btn_b_n = 2'b11;
    bus1.btn_a_n = 2'b11; bus1.btn_b_n = 2'b11;
    $display("priority checked");

    // Frame gating mid-attack
    tick(); tick(); tick();
    check_val("gate_pre_win", bus0.attack_active[0], 1);
    bus0.finished = 1'b0; bus1.finished = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      check_val($sformatf("gate_state k%0d", k), s0p0, 1);
      check_val($sformatf("gate_win k%0d", k), bus0.attack_active[0], 1);
    end
    bus0.finished = 1'b1; bus1.finished = 1'b1;
    tick();
    check_val("gate_cnt4", bus0.attack_active[0], 1);
    tick();
    check_val("gate_cnt5", bus0.attack_active[0], 1);
    tick();
    check_val("gate_cnt6_win", bus0.attack_active[0], 0);
    check_val("gate_cnt6_state", s0p0, 1);
    $display("frame gating checked");

    // Reset mid-attack takes effect before the next edge
    rst = 1'b0;
    #1;
    check_val("midrst_state", s0p0, 0);
    check_val("midrst_rest", bus0.resting, 2'b11);
    check_val("midrst_win", bus0.attack_active, 0);
    check_val("midrst_blk", bus0.block_active, 0);
    tick();
    rst = 1'b1;
    $display("mid-action reset checked");

    // Two players concurrently: p0 attacks, p1 blocks then is hit in cooldown
    bus0.btn_a_n = 2'b10;
    bus0.btn_b_n = 2'b01;
    for (int k = 0; k < 8; k++) begin
      bus0.hit_in = (k == 7) ? 2'b10 : 2'b00;
      tick();
      check_val($sformatf("dual_p0 k%0d", k), s0p0, 1);
      check_val($sformatf("dual_p1 k%0d", k), s0p1, (k < 6) ? 2 : ((k == 6) ? 3 : 4));
      check_val($sformatf("dual_atk k%0d", k), bus0.attack_active,
                (k >= 3 && k <= 5) ? 2'b01 : 2'b00);
      check_val($sformatf("dual_blk k%0d", k), bus0.block_active, (k < 6) ? 2'b10 : 2'b00);
      check_val($sformatf("dual_rest k%0d", k), bus0.resting, (k < 6) ? 2'b00 : 2'b10);
      check_val($sformatf("dual_hit k%0d", k), bus0.hit_taken, (k == 7) ? 2'b10 : 2'b00);
    end
    bus0.hit_in = 2'b00;
    bus0.btn_a_n = 2'b11;
    bus0.btn_b_n = 2'b11;
    $display("two-player sequence done");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
